// File: rtl/rob_multiport.sv
// rob_multiport: 2-wide in-order allocate/retire reorder buffer, 2 writeback ports, register lookup; `define ROB_FLUSH_EN adds tag flush
module rob_multiport #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ROB_FLUSH_EN
    input  logic              flush_valid,
    input  logic [TAG_W-1:0]  flush_tag,
`endif
    input  logic [1:0]        alloc_req,
    input  logic [REG_AW-1:0] alloc_dst0,
    input  logic [REG_AW-1:0] alloc_dst1,
    input  logic              alloc_wen0,
    input  logic              alloc_wen1,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag0,
    output logic [TAG_W-1:0]  alloc_tag1,
    input  logic              wb_valid0,
    input  logic              wb_valid1,
    input  logic [TAG_W-1:0]  wb_tag0,
    input  logic [TAG_W-1:0]  wb_tag1,
    input  logic [DATA_W-1:0] wb_data0,
    input  logic [DATA_W-1:0] wb_data1,
    input  logic [REG_AW-1:0] lk_reg,
    output logic              lk_hit,
    output logic              lk_done,
    output logic [DATA_W-1:0] lk_data,
    output logic [TAG_W-1:0]  lk_tag,
    output logic              cm_we1,
    output logic              cm_we2,
    output logic [REG_AW-1:0] cm_reg1,
    output logic [REG_AW-1:0] cm_reg2,
    output logic [DATA_W-1:0] cm_data1,
    output logic [DATA_W-1:0] cm_data2,
    output logic [1:0]        cm_retire,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, wen_q, wen_d;
    logic [REG_AW-1:0] dst_q [DEPTH];
    logic [REG_AW-1:0] dst_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W:0] head_q, head_d, tail_q, tail_d;
    logic cm_we1_q, cm_we2_q;
    logic [REG_AW-1:0] cm_reg1_q, cm_reg2_q;
    logic [DATA_W-1:0] cm_data1_q, cm_data2_q;
    logic [1:0] cm_retire_q;
    logic [TAG_W-1:0] h, h1, t, lk_idx, f_off;
    logic a0, a1, ret1, ret2, fl;

    assign h = head_q[TAG_W-1:0];
    assign h1 = h + TAG_W'(1);
    assign t = tail_q[TAG_W-1:0];
    assign count = tail_q - head_q;
    assign empty = tail_q == head_q;
    assign full = (tail_q ^ head_q) == {1'b1, {TAG_W{1'b0}}};
    assign alloc_ready = count <= (TAG_W+1)'(DEPTH - 2);
    assign alloc_tag0 = t;
    assign alloc_tag1 = t + TAG_W'(1);
    assign a0 = alloc_ready & alloc_req[0];
    assign a1 = a0 & alloc_req[1];
`ifdef ROB_FLUSH_EN
    assign fl = flush_valid & valid_q[flush_tag];
    assign f_off = flush_tag - h;
`else
    assign fl = 1'b0;
    assign f_off = '0;
`endif
    // A flush at the head itself keeps everything behind it from retiring
    assign ret1 = valid_q[h] & done_q[h];
    assign ret2 = ret1 & valid_q[h1] & done_q[h1] & ~(fl && f_off == '0);
    assign lk_tag = lk_idx;
    assign lk_done = lk_hit & done_q[lk_idx];
    assign lk_data = lk_done ? data_q[lk_idx] : '0;
    assign cm_we1 = cm_we1_q;
    assign cm_we2 = cm_we2_q;
    assign cm_reg1 = cm_reg1_q;
    assign cm_reg2 = cm_reg2_q;
    assign cm_data1 = cm_data1_q;
    assign cm_data2 = cm_data2_q;
    assign cm_retire = cm_retire_q;

    // Entry next state: allocate, writeback (port 1 last so it wins), retire, then flush
    always_comb begin
        valid_d = valid_q;
        done_d = done_q;
        wen_d = wen_q;
        dst_d = dst_q;
        data_d = data_q;
        head_d = head_q + (TAG_W+1)'(ret1) + (TAG_W+1)'(ret2);
        tail_d = tail_q + (TAG_W+1)'(a0) + (TAG_W+1)'(a1);
        if (a0) begin
            valid_d[t] = 1'b1;
            done_d[t] = 1'b0;
            wen_d[t] = alloc_wen0;
            dst_d[t] = alloc_dst0;
        end
        if (a1) begin
            valid_d[alloc_tag1] = 1'b1;
            done_d[alloc_tag1] = 1'b0;
            wen_d[alloc_tag1] = alloc_wen1;
            dst_d[alloc_tag1] = alloc_dst1;
        end
        if (wb_valid0 && valid_q[wb_tag0]) begin
            done_d[wb_tag0] = 1'b1;
            data_d[wb_tag0] = wb_data0;
        end
        if (wb_valid1 && valid_q[wb_tag1]) begin
            done_d[wb_tag1] = 1'b1;
            data_d[wb_tag1] = wb_data1;
        end
        if (ret1) valid_d[h] = 1'b0;
        if (ret2) valid_d[h1] = 1'b0;
        if (fl) begin
            tail_d = head_q + (TAG_W+1)'(f_off) + (TAG_W+1)'(1);
            for (int i = 0; i < DEPTH; i++)
                if (TAG_W'(i) - h > f_off) valid_d[i] = 1'b0;
        end
    end

    // Lookup walks oldest to youngest so the last match is the youngest producer
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (lk_reg != '0 && valid_q[h + TAG_W'(i)] && wen_q[h + TAG_W'(i)] && dst_q[h + TAG_W'(i)] == lk_reg) begin
                lk_hit = 1'b1;
                lk_idx = h + TAG_W'(i);
            end
    end

    // Pointers, status bits and registered commit ports
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            valid_q <= '0;
            done_q <= '0;
            wen_q <= '0;
            cm_we1_q <= 1'b0;
            cm_we2_q <= 1'b0;
            cm_reg1_q <= '0;
            cm_reg2_q <= '0;
            cm_data1_q <= '0;
            cm_data2_q <= '0;
            cm_retire_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            valid_q <= valid_d;
            done_q <= done_d;
            wen_q <= wen_d;
            cm_we1_q <= ret1 & wen_q[h];
            cm_we2_q <= ret2 & wen_q[h1];
            cm_reg1_q <= ret1 ? dst_q[h] : '0;
            cm_reg2_q <= ret2 ? dst_q[h1] : '0;
            cm_data1_q <= ret1 ? data_q[h] : '0;
            cm_data2_q <= ret2 ? data_q[h1] : '0;
            cm_retire_q <= {ret2, ret1 & ~ret2};
        end
    end

    // Entry payload needs no reset; valid bits guard it
    always_ff @(posedge clk) begin
        dst_q <= dst_d;
        data_q <= data_d;
    end
endmodule
